// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding read between the PC stage and instruction memory.
// Optional build macro IFU_ALIGN_CHECK_EN turns misaligned PCs into local fetch faults.
module ifu_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        pc_valid,
    input  logic        flush,
    output logic        fetch_busy,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        rsp_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_err,
    input  logic        inst_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    logic [1:0] state;
    logic       drop;

    assign fetch_busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            drop       <= 1'b0;
            req_valid  <= 1'b0;
            req_addr   <= RESET_ADDR;
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= RESET_ADDR;
            inst_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_valid && !flush) begin
`ifdef IFU_ALIGN_CHECK_EN
                        if (pc[1:0] != 2'b00) begin
                            inst       <= 32'h0;
                            inst_err   <= 1'b1;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            req_addr  <= pc;
                            req_valid <= 1'b1;
                            state     <= REQ;
                        end
`else
                        req_addr  <= {pc[31:2], 2'b00};
                        req_valid <= 1'b1;
                        state     <= REQ;
`endif
                    end
                end
                REQ: begin
                    // A raised request is never withdrawn; a flush only marks it for discard.
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rsp_valid) begin
                        if (drop || flush) begin
                            drop  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            inst       <= rsp_data;
                            inst_err   <= rsp_err;
                            inst_pc    <= req_addr;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (flush || inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: the bench plays PC stage, memory and decode,
// and checks each fetch transaction against rules derived from the fetch protocol.
module tb_ifu_fetch;

    localparam logic [31:0] RST_A = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        pc_valid = 1'b0;
    logic        flush = 1'b0;
    logic        fetch_busy;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b0;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        rsp_err = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        inst_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    ifu_fetch #(.RESET_ADDR(RST_A)) dut (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .fetch_busy(fetch_busy), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_err(inst_err), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    // Memory-side view: every accepted read request.
    always @(posedge clk) begin
        if (!rst && req_valid && req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_req_valid", 32'(req_valid), 32'd0);
        chk("rst_req_addr", req_addr, RST_A);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, RST_A);
        chk("rst_inst_err", 32'(inst_err), 32'd0);
        chk("rst_busy", 32'(fetch_busy), 32'd0);
    endtask

    // fl: 0 none, 1 flush in request phase, 2 flush while awaiting response, 3 flush in hold
    task automatic fetch(input logic [31:0] a, input int rdy_dly, input int rsp_dly,
                         input logic [31:0] d, input logic e, input int ir_dly, input int fl);
        logic [31:0] ea;
        int hs0;
        ea  = {a[31:2], 2'b00};
        hs0 = hs_cnt;
        pc = a;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        pc = $urandom;
        chk("busy_rise", 32'(fetch_busy), 32'd1);
`ifdef IFU_ALIGN_CHECK_EN
        if (a[1:0] != 2'b00) begin
            chk("mis_req_valid", 32'(req_valid), 32'd0);
            chk("mis_inst_valid", 32'(inst_valid), 32'd1);
            chk("mis_inst_err", 32'(inst_err), 32'd1);
            chk("mis_inst", inst, 32'h0);
            chk("mis_inst_pc", inst_pc, a);
            inst_ready = 1'b1;
            step();
            inst_ready = 1'b0;
            chk("mis_done", 32'(inst_valid), 32'd0);
            chk("mis_no_req", 32'(hs_cnt - hs0), 32'd0);
            return;
        end
`endif
        chk("req_valid", 32'(req_valid), 32'd1);
        chk("req_addr", req_addr, ea);
        for (int i = 0; i <= rdy_dly; i++) begin
            req_ready = (i == rdy_dly);
            flush     = (fl == 1 && i == 0);
            rsp_valid = (i != rdy_dly) && ($urandom_range(0, 1) == 1);
            rsp_data  = $urandom;
            rsp_err   = 1'($urandom_range(0, 1));
            step();
            flush = 1'b0;
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            chk("req_hold_valid", 32'(req_valid), (i != rdy_dly) ? 32'd1 : 32'd0);
            if (i != rdy_dly) chk("req_hold_addr", req_addr, ea);
            chk("req_no_inst", 32'(inst_valid), 32'd0);
        end
        for (int i = 0; i <= rsp_dly; i++) begin
            flush     = (fl == 2 && i == 0);
            rsp_valid = (i == rsp_dly);
            rsp_data  = (i == rsp_dly) ? d : 32'($urandom);
            rsp_err   = (i == rsp_dly) ? e : 1'b0;
            step();
            flush = 1'b0;
            rsp_valid = 1'b0;
            if (i != rsp_dly) begin
                chk("wait_busy", 32'(fetch_busy), 32'd1);
                chk("wait_no_inst", 32'(inst_valid), 32'd0);
            end
        end
        chk("one_request", 32'(hs_cnt - hs0), 32'd1);
        if (fl == 1 || fl == 2) begin
            chk("drop_no_inst", 32'(inst_valid), 32'd0);
            chk("drop_idle", 32'(fetch_busy), 32'd0);
            return;
        end
        chk("inst_valid", 32'(inst_valid), 32'd1);
        chk("inst", inst, d);
        chk("inst_pc", inst_pc, ea);
        chk("inst_err", 32'(inst_err), 32'(e));
        chk("hold_busy", 32'(fetch_busy), 32'd1);
        if (fl == 3) begin
            flush = 1'b1;
            inst_ready = (ir_dly == 0);
            step();
            flush = 1'b0;
            inst_ready = 1'b0;
            chk("hold_flush_valid", 32'(inst_valid), 32'd0);
            chk("hold_flush_idle", 32'(fetch_busy), 32'd0);
            return;
        end
        for (int i = 0; i <= ir_dly; i++) begin
            inst_ready = (i == ir_dly);
            step();
            inst_ready = 1'b0;
            if (i != ir_dly) begin
                chk("stall_valid", 32'(inst_valid), 32'd1);
                chk("stall_inst", inst, d);
                chk("stall_inst_pc", inst_pc, ea);
                chk("stall_inst_err", 32'(inst_err), 32'(e));
            end
        end
        chk("accept_valid", 32'(inst_valid), 32'd0);
        chk("accept_idle", 32'(fetch_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int fl;
        int rd;

        // Reset
        rst = 1'b1;
        repeat (2) step();
        chk_reset_values();
        rst = 1'b0;
        step();
        chk_reset_values();

        // Basic fetch at minimum latency
        fetch(32'h8000_0000, 0, 0, 32'h0000_0413, 1'b0, 0, 0);
        // Backpressure on both sides
        fetch(32'h8000_0008, 3, 0, 32'h1234_5678, 1'b0, 2, 0);
        // Flush while awaiting response, then a normal fetch
        fetch(32'h8000_0004, 0, 1, 32'hDEAD_BEEF, 1'b0, 0, 2);
        fetch(32'h8000_0100, 0, 0, 32'h0010_0093, 1'b0, 0, 0);
        // Flush during request phase
        fetch(32'h8000_0200, 2, 1, 32'hCAFE_F00D, 1'b0, 0, 1);
        // Flush together with inst_ready in HOLD
        fetch(32'h8000_0300, 0, 0, 32'h0000_0013, 1'b0, 0, 3);
        // Memory fault
        fetch(32'h8000_0010, 0, 0, 32'h0, 1'b1, 0, 0);
        // Misaligned PC
        fetch(32'h8000_0002, 0, 0, 32'h0000_0517, 1'b0, 1, 0);

        // Flush in IDLE masks a simultaneous pc_valid
        pc = 32'h8000_0400;
        pc_valid = 1'b1;
        flush = 1'b1;
        step();
        pc_valid = 1'b0;
        flush = 1'b0;
        chk("idle_flush_busy", 32'(fetch_busy), 32'd0);
        chk("idle_flush_req", 32'(req_valid), 32'd0);

        // Reset while awaiting response, then a stray response
        pc = 32'h8000_0040;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("pre_rst_busy", 32'(fetch_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_values();
        rsp_valid = 1'b1;
        rsp_data = 32'hBAD0_BAD0;
        rsp_err = 1'b1;
        step();
        rsp_valid = 1'b0;
        rsp_err = 1'b0;
        chk("stray_inst_valid", 32'(inst_valid), 32'd0);
        chk("stray_inst", inst, 32'h0);
        chk("stray_busy", 32'(fetch_busy), 32'd0);

        // Randomized transactions with idle gaps containing stray responses
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
`ifdef IFU_ALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
`endif
            fl = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
            rd = int'($urandom_range(0, 3));
            if (fl == 2 && rd == 0) rd = 1;
            fetch(a, int'($urandom_range(0, 3)), rd, $urandom, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), fl);
            if ($urandom_range(0, 1) == 1) begin
                rsp_valid = 1'b1;
                rsp_data = $urandom;
                step();
                rsp_valid = 1'b0;
                chk("gap_no_inst", 32'(inst_valid), 32'd0);
                chk("gap_idle", 32'(fetch_busy), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit sitting between the PC register and instruction memory. It consumes the current `pc`, issues a single outstanding read request on a valid/ready memory port, buffers the returned word, and presents it to decode with a valid/ready handshake. It drives `fetch_busy` back to the PC logic so the PC does not advance while a fetch is in flight, and it discards in-flight fetches on a redirect (`flush`).

## Interface
Parameters:
- `RESET_ADDR`, `32'h8000_0000`: value of `req_addr` and `inst_pc` after reset.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high.
- `pc` in 32: address to fetch; sampled when `pc_valid` is accepted.
- `pc_valid` in 1: fetch request from the PC stage.
- `flush` in 1: redirect (jump taken); kill current fetch.
- `fetch_busy` out 1: PC must hold its value while this is high.
- `req_valid` out 1: memory read request valid.
- `req_addr` out 32: memory read address.
- `req_ready` in 1: memory accepts request.
- `rsp_valid` in 1: memory read data valid.
- `rsp_data` in 32: memory read data.
- `rsp_err` in 1: memory access fault.
- `inst_valid` out 1: instruction valid to decode.
- `inst` out 32: instruction word.
- `inst_pc` out 32: address of `inst`.
- `inst_err` out 1: fetch fault for `inst`.
- `inst_ready` in 1: decode accepts instruction.

## Operation
FSM states are IDLE, REQ, WAIT and HOLD. All outputs are registered, except that `fetch_busy` is `state != IDLE`.

- **IDLE**
  - On `pc_valid & !flush`: latch `req_addr <= pc`, set `req_valid <= 1`, go to REQ.
  - Otherwise stay in IDLE.
- **REQ**
  - `req_valid` and `req_addr` stay stable until `req_valid & req_ready`.
  - On that handshake: `req_valid <= 0`, go to WAIT.
  - A request cannot be withdrawn once raised.
- **WAIT**
  - On `rsp_valid`: capture `rsp_data` into `inst`, `rsp_err` into `inst_err`, `req_addr` into `inst_pc`.
  - Set `inst_valid <= 1` and go to HOLD.
- **HOLD**
  - `inst`, `inst_pc` and `inst_err` stay stable while `inst_valid & !inst_ready`.
  - On `inst_ready`: `inst_valid <= 0`, go to IDLE.
- **Flush**
  - In IDLE: no effect, and `pc_valid` in the same cycle is ignored.
  - In REQ or WAIT: set the `drop` flag. The request still completes its handshake. The response is consumed without raising `inst_valid`, `drop` is cleared, and the FSM returns to IDLE.
  - In HOLD: `inst_valid <= 0` and go to IDLE. Flush takes priority over a simultaneous `inst_ready`.
- **Responses and errors**
  - `rsp_valid` outside WAIT is a protocol violation; it is ignored and changes no state.
  - A memory fault is passed through as `inst_err = 1`. It is not retried.

## Timing
- **Reset**: state IDLE, `req_valid = 0`, `req_addr = RESET_ADDR`, `inst_valid = 0`, `inst = 0`, `inst_pc = RESET_ADDR`, `inst_err = 0`, `drop = 0`, `fetch_busy = 0`.
  - Reset asserted mid-operation abandons the outstanding request immediately.
  - The memory side must also be reset in the same cycle.
- **Minimum latency**, with `req_ready = 1` and the response one cycle after acceptance:
  - `pc_valid` in cycle 0.
  - `req_valid` in cycle 1.
  - `rsp_valid` in cycle 2.
  - `inst_valid` in cycle 3.
  - Back in IDLE in cycle 4 if `inst_ready = 1` in cycle 3.
- **Throughput**: one instruction per 4 cycles at best.
- **Outstanding requests**: at most one.
- **`fetch_busy`**: rises the cycle after `pc_valid` is accepted and falls the cycle after the `inst` handshake or flush-return to IDLE.

## Configuration
`IFU_ALIGN_CHECK_EN`:
- **Defined**:
  - When `pc[1:0] != 0` is accepted in IDLE, no memory request is issued.
  - The FSM goes directly to HOLD with `inst = 0`, `inst_err = 1`, `inst_pc = pc`, and `inst_valid = 1` the next cycle.
- **Undefined**:
  - `req_addr` is `{pc[31:2], 2'b00}`; the low bits are silently dropped.
  - `inst_pc` carries the same aligned address.

## Test plan
- **Basic fetch**: reset, then `pc = 32'h8000_0000`, `pc_valid = 1`, `req_ready = 1`, response `32'h0000_0413` one cycle later, `inst_ready = 1` -> `inst_valid` in cycle 3 with `inst = 32'h0000_0413`, `inst_pc = 32'h8000_0000`, `inst_err = 0`; `fetch_busy` high in cycles 1–3.
- **Backpressure**: `req_ready` low for 3 cycles, then `inst_ready` low for 2 cycles -> `req_addr` stable throughout; `inst` and `inst_pc` unchanged until `inst_ready`; exactly one request issued.
- **Flush in WAIT**: flush while awaiting the response to `32'h8000_0004` -> response `32'hDEAD_BEEF` dropped, `inst_valid` never rises, FSM in IDLE; the next `pc = 32'h8000_0100` fetches normally.
- **Flush and `inst_ready` in HOLD**: both asserted together -> `inst_valid` low next cycle; treated as flushed.
- **Fault**: `rsp_err = 1` with `rsp_data = 0` -> `inst_valid = 1`, `inst_err = 1`.
  - With `IFU_ALIGN_CHECK_EN` defined, `pc = 32'h8000_0002` -> no `req_valid`; `inst_err = 1`, `inst_pc = 32'h8000_0002`.
  - With it undefined, `pc = 32'h8000_0002` -> `req_addr = 32'h8000_0000`.
- **Reset mid-operation**: `rst` asserted in WAIT -> all outputs at reset values the next cycle; a later stray `rsp_valid` is ignored.
